// File: rtl/cis_line_capture.sv
// rtl/cis_line_capture.sv - CIS start-pulse generator and ADC byte-to-pixel line capture
module cis_line_capture #(
    parameter int SP_WIDTH  = 4,
    parameter int DUMMY_PIX = 2,
    parameter int PIXELS    = 8
) (
    input  logic        adc_clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        start_cis,
    input  logic [15:0] sp_para,
    input  logic [7:0]  ad_data,
    input  logic        pix_ready,
    output logic        cis_sp,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        pix_last,
    output logic        line_start,
    output logic        line_done,
    output logic [15:0] line_count,
    output logic        overrun
);

    // Shortest line that still fits SP, the dummy pixels and every active pixel.
    localparam logic [15:0] MIN_PERIOD = 16'(SP_WIDTH + 2 * (DUMMY_PIX + PIXELS));
    // line_cnt value of the final cycle of SP and of DUMMY respectively.
    localparam logic [15:0] SP_END     = 16'(SP_WIDTH - 1);
    localparam logic [15:0] DUMMY_END  = 16'(SP_WIDTH + 2 * DUMMY_PIX - 1);
    localparam logic [11:0] LAST_IDX   = 12'(PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SP    = 3'd1,
        DUMMY = 3'd2,
        CAPT  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        enter_sp;

    logic [15:0] period;
    logic [15:0] period_req;
    logic [15:0] line_cnt;
    logic        phase;
    logic [11:0] pix_idx;
    logic [7:0]  hi_byte;

    logic        run_ok;
    logic        line_end;
    logic        pix_event;
    logic        last_pix;

    assign run_ok     = start_cis && init_done;
    // sp_para below the minimum (including 0) is stretched to the minimum.
    assign period_req = (sp_para < MIN_PERIOD) ? MIN_PERIOD : sp_para;
    // Only reachable from CAPT (last cycle, when period is minimal) or GAP.
    assign line_end   = ((state == CAPT) || (state == GAP)) && (line_cnt == period - 16'd1);
    assign pix_event  = (state == CAPT) && phase;
    assign last_pix   = pix_event && (pix_idx == LAST_IDX);

    // State register.
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; start_cis/init_done are only looked at in IDLE and at line end.
    always_comb begin
        state_nx = state;
        enter_sp = 1'b0;
        case (state)
            IDLE: begin
                if (run_ok) begin
                    state_nx = SP;
                    enter_sp = 1'b1;
                end
            end
            SP: begin
                if (line_cnt == SP_END) begin
                    state_nx = (DUMMY_PIX == 0) ? CAPT : DUMMY;
                end
            end
            DUMMY: begin
                if (line_cnt == DUMMY_END) begin
                    state_nx = CAPT;
                end
            end
            CAPT: begin
                if (last_pix) begin
                    if (line_end) begin
                        state_nx = run_ok ? SP : IDLE;
                        enter_sp = run_ok;
                    end else begin
                        state_nx = GAP;
                    end
                end
            end
            GAP: begin
                if (line_end) begin
                    state_nx = run_ok ? SP : IDLE;
                    enter_sp = run_ok;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Line timing: period latched and cycle counter restarted on every SP entry.
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            period   <= 16'd0;
            line_cnt <= 16'd0;
        end else if (enter_sp) begin
            period   <= period_req;
            line_cnt <= 16'd0;
        end else if (state != IDLE) begin
            line_cnt <= line_cnt + 16'd1;
        end
    end

    // Byte demux: phase 0 holds the high byte, phase 1 completes the pixel.
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            phase   <= 1'b0;
            pix_idx <= 12'd0;
            hi_byte <= 8'd0;
        end else if (enter_sp) begin
            phase   <= 1'b0;
            pix_idx <= 12'd0;
        end else if (state == CAPT) begin
            phase <= ~phase;
            if (!phase) begin
                hi_byte <= ad_data;
            end else begin
                pix_idx <= pix_idx + 12'd1;
            end
        end
    end

    // Registered strobes: cis_sp mirrors the SP state, line_start marks SP entry.
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            cis_sp     <= 1'b0;
            line_start <= 1'b0;
            line_done  <= 1'b0;
            line_count <= 16'd0;
        end else begin
            cis_sp     <= (state_nx == SP);
            line_start <= enter_sp;
            line_done  <= last_pix;
            if (last_pix) begin
                line_count <= line_count + 16'd1;
            end
        end
    end

    // One-entry output register; a pixel arriving while the held one is stalled is lost.
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            pix_data  <= 16'd0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
        end else if (pix_event) begin
            if (!pix_valid || pix_ready) begin
                pix_data  <= {hi_byte, ad_data};
                pix_valid <= 1'b1;
                pix_last  <= (pix_idx == LAST_IDX);
            end
        end else if (pix_ready) begin
            pix_valid <= 1'b0;
        end
    end

    // Sticky overrun flag, cleared only when a fresh run starts from IDLE.
    always_ff @(posedge adc_clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if ((state == IDLE) && enter_sp) begin
            overrun <= 1'b0;
        end else if (pix_event && pix_valid && !pix_ready) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: doc/cis_line_capture.md
# cis_line_capture

Downstream stage of the CIS analog-front-end controller. Once ADC configuration completes, it generates the CIS start pulse (`cis_sp`) at a programmable line period. Each line, it de-multiplexes the ADC's byte-wide output (high byte, then low byte) into 16-bit pixels. Pixels go to the line buffer through a one-entry valid/ready output register, with overrun detection.

## Interface
Parameters:
- `SP_WIDTH`, 4: `cis_sp` high time in `adc_clk` cycles (≥1)
- `DUMMY_PIX`, 2: dummy pixels discarded after SP (≥0)
- `PIXELS`, 8: active pixels per line (≥1, ≤4095)

Ports (one clock; reset is asynchronous and active-high):
- `adc_clk`  in  1  sole clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `init_done`  in  1  ADC configuration complete (level)
- `start_cis`  in  1  run-enable for line capture (level)
- `sp_para`  in  16  requested line period in `adc_clk` cycles
- `ad_data`  in  8  ADC output byte, high/low multiplexed
- `pix_ready`  in  1  downstream accepts pixel
- `cis_sp`  out  1  CIS line start pulse
- `pix_data`  out  16  pixel `{hi, lo}`
- `pix_valid`  out  1  `pix_data` valid
- `pix_last`  out  1  `pix_data` is last pixel of line
- `line_start`  out  1  one-cycle pulse on first SP cycle
- `line_done`  out  1  one-cycle pulse when last pixel loads
- `line_count`  out  16  completed lines, wraps `0xFFFF`→0
- `overrun`  out  1  sticky: pixel dropped

## Operation
- `MIN_PERIOD` = `SP_WIDTH` + 2·(`DUMMY_PIX`+`PIXELS`).
- `period` is latched on SP entry as max(`sp_para`, `MIN_PERIOD`), so `sp_para`=0 is treated as `MIN_PERIOD`.
- `line_cnt` (16 bit) is 0 on SP entry and increments every cycle of the line.
- States: IDLE, SP, DUMMY, CAPT, GAP.
  - IDLE: if `start_cis`&&`init_done` → SP. Entering SP from IDLE also clears `overrun`.
  - SP: lasts `line_cnt` 0..`SP_WIDTH`-1, then → DUMMY, or → CAPT if `DUMMY_PIX`=0.
  - DUMMY: lasts 2·`DUMMY_PIX` cycles. `ad_data` is ignored.
  - CAPT: lasts 2·`PIXELS` cycles. A `phase` bit starts at 0.
    - phase 0: register `ad_data` as hi.
    - phase 1: form pixel `{hi, ad_data}` and present it to the output register.
    - After the last phase-1 cycle → GAP, or straight to line end if `line_cnt`=`period`-1.
  - GAP: wait until `line_cnt`=`period`-1.
  - Line end (`line_cnt`=`period`-1): if `start_cis`&&`init_done`, go to SP with `line_cnt`←0; else go to IDLE.
- `start_cis` is sampled only in IDLE and at line end. Dropping it mid-line completes the current line.
- `init_done` dropping mid-line likewise takes effect only at line end.
- Output register rules:
  - Load on a pixel-complete event when `!pix_valid || pix_ready`. `pix_valid` then becomes or stays 1.
  - If `pix_valid && !pix_ready` at pixel-complete: the new pixel is dropped, `overrun`←1, and the held pixel is unchanged.
  - `pix_ready` with no new pixel: `pix_valid`←0.
- `pix_last` is loaded with the pixel and is 1 for pixel `PIXELS`-1.
- `line_done` pulses whenever the last pixel completes, even if that pixel was dropped.
- `line_count` increments on each `line_done`.

## Timing
- Reset values: state=IDLE; `cis_sp`, `pix_valid`, `pix_last`, `line_start`, `line_done`, `overrun` = 0; `pix_data`, `line_count`, `line_cnt`, `phase` = 0.
- All outputs are registered. `cis_sp` is high exactly while state=SP.
- Let cycle L be the cycle the SP→first-line-cycle edge is taken (`line_cnt`=0).
  - `cis_sp` and `line_start` rise on the edge into L. `line_start` lasts 1 cycle; `cis_sp` lasts `SP_WIDTH` cycles.
  - The hi byte of pixel k is sampled at the end of cycle L+`SP_WIDTH`+2·`DUMMY_PIX`+2k; the lo byte is sampled one cycle later.
  - Pixel k is visible on `pix_data`/`pix_valid` in the following cycle: 2-cycle latency from the hi sample.
  - `line_done`, and `pix_last` when loaded, appear in the same cycle as the last pixel.
- The next SP starts at cycle L+`period`; there are no idle cycles between back-to-back lines.
- Reset asserted mid-line: immediate return to reset values, no partial pixel output.

## Test plan
- Defaults, `sp_para`=0, `pix_ready`=1, `ad_data`=cycle index → `cis_sp` high for 4 cycles every 24 cycles. `pix_data` = `0x0809`, `0x0A0B`, … `0x1617`. `pix_last` on `0x1617`. `line_count` increments every 24 cycles.
- `sp_para`=40 → SP period is 40 cycles. GAP lasts 16 cycles. `line_start` is spaced 40 cycles apart.
- `pix_ready`=0 for the whole line → first pixel `0x0809` is held. `overrun`=1 after pixel 1. `line_done` still pulses. On the next start from IDLE, `overrun` clears.
- `pix_ready` toggled 1/0 every cycle → no overrun: each pixel completes every 2 cycles. All 8 pixels are delivered in order.
- `start_cis` deasserted at `line_cnt`=10 → the line completes with all 8 pixels, then IDLE. `cis_sp` stays low afterward.
- `init_done`=0 with `start_cis`=1 → `cis_sp` never asserts. Then assert `reset` during CAPT → all outputs return to 0 within the same cycle.
